// File: rtl/db15_pkg.sv
// Shared definitions for the DB15 serial joystick reader: scan states and
// the width of the published joystick words.
package db15_pkg;
  localparam int JOY_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    EVAL
  } state_e;
endpackage

// File: rtl/db15_serial_reader_if.sv
// Adapter-side lines of the DB15 serial joystick link. The reader drives
// clock and load; the adapter returns serial data.
interface db15_serial_reader_if;
  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (output joy_clk, output joy_load, input joy_data);
  modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/db15_frame_filter.sv
// Frame-level debounce and presence detection: publishes a raw frame only
// after DEB_FRAMES identical captures; an all-zero frame means no adapter.
module db15_frame_filter
  import db15_pkg::*;
#(
  parameter int NBITS      = 12,
  parameter int DEB_FRAMES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*NBITS-1:0] raw,
  input  logic               eval,
  output logic [JOY_W-1:0]   joystick1,
  output logic [JOY_W-1:0]   joystick2,
  output logic               frame_stb,
  output logic               present
);

  localparam int FW = 2 * NBITS;
  localparam int CW = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;

  logic [FW-1:0]    prev_q, prev_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [JOY_W-1:0] joy1_q, joy1_d, joy2_q, joy2_d;
  logic             present_q, present_d;
  logic             stb_q, stb_d;

  always_comb begin
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    joy1_d    = joy1_q;
    joy2_d    = joy2_q;
    present_d = present_q;
    stb_d     = eval;
    if (eval) begin
      prev_d = raw;
      if (raw == prev_q) begin
        cnt_d = (cnt_q == CW'(DEB_FRAMES - 1)) ? cnt_q : cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
      // A frame stuck at all zeros is what a missing adapter looks like.
      if (raw == '0) begin
        present_d = 1'b0;
        joy1_d    = '0;
        joy2_d    = '0;
      end else begin
        present_d = 1'b1;
        if (cnt_d == CW'(DEB_FRAMES - 1)) begin
          joy1_d            = '0;
          joy2_d            = '0;
          joy1_d[NBITS-1:0] = ~raw[NBITS-1:0];
          joy2_d[NBITS-1:0] = ~raw[FW-1:NBITS];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= '0;
      cnt_q     <= '0;
      joy1_q    <= '0;
      joy2_q    <= '0;
      present_q <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      joy1_q    <= joy1_d;
      joy2_q    <= joy2_d;
      present_q <= present_d;
      stb_q     <= stb_d;
    end
  end

  assign joystick1 = joy1_q;
  assign joystick2 = joy2_q;
  assign present   = present_q;
  assign frame_stb = stb_q;

endmodule

// File: rtl/db15_serial_reader.sv
// DB15 serial joystick scanner: drives the adapter's load/clock lines, shifts
// in both players' buttons and hands each full frame to the debounce filter.
module db15_serial_reader
  import db15_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int NBITS      = 12,
  parameter int GAP        = 64,
  parameter int DEB_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  db15_serial_reader_if.master joy,
  output logic [JOY_W-1:0]     joystick1,
  output logic [JOY_W-1:0]     joystick2,
  output logic                 frame_stb,
  output logic                 present
);

  localparam int FW   = 2 * NBITS;
  localparam int BW   = (FW > 1) ? $clog2(FW) : 1;
  localparam int TMAX = (GAP > 2 * CLK_DIV) ? GAP : 2 * CLK_DIV;
  localparam int TW   = $clog2(TMAX + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          hi_q, hi_d;
  logic [FW-1:0] raw_q, raw_d;
  logic [1:0]    sync_q, sync_d;
  logic          joy_clk_q, joy_clk_d;
  logic          joy_load_q, joy_load_d;
  logic          eval;
  logic          data_s;

  // joy_data is asynchronous to clk; only the second stage is ever used.
  assign data_s = sync_q[1];

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    raw_d   = raw_q;
    sync_d  = {sync_q[0], joy.joy_data};
    eval    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tmr_q == TW'(GAP - 1)) begin
          state_d = LOAD;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      LOAD: begin
        if (tmr_q == TW'(2 * CLK_DIV - 1)) begin
          state_d = SHIFT;
          tmr_d   = '0;
          hi_d    = 1'b0;
          bit_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      SHIFT: begin
        if (tmr_q == TW'(CLK_DIV - 1)) begin
          tmr_d = '0;
          hi_d  = ~hi_q;
          // Sample at the end of the low phase, when the adapter output has
          // had the whole phase to settle through the synchroniser.
          if (!hi_q) begin
            raw_d[bit_q] = data_s;
          end else if (bit_q == BW'(FW - 1)) begin
            state_d = EVAL;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      EVAL: begin
        eval    = 1'b1;
        state_d = IDLE;
        tmr_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    // Line levels are decoded from the next state so the pins come from flops.
    joy_load_d = (state_d != LOAD);
    joy_clk_d  = !((state_d == SHIFT) && !hi_d);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      bit_q      <= '0;
      hi_q       <= 1'b0;
      raw_q      <= '0;
      sync_q     <= 2'b11;
      joy_clk_q  <= 1'b1;
      joy_load_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      hi_q       <= hi_d;
      raw_q      <= raw_d;
      sync_q     <= sync_d;
      joy_clk_q  <= joy_clk_d;
      joy_load_q <= joy_load_d;
    end
  end

  assign joy.joy_clk  = joy_clk_q;
  assign joy.joy_load = joy_load_q;

  db15_frame_filter #(
    .NBITS      (NBITS),
    .DEB_FRAMES (DEB_FRAMES)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .raw       (raw_q),
    .eval      (eval),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .frame_stb (frame_stb),
    .present   (present)
  );

endmodule

// File: tb/tb_db15_serial_reader.sv
// Bench for db15_serial_reader: three configurations run side by side against
// a behavioural adapter and a frame-history reference model.
module tb_db15_serial_reader;

  logic        clk;
  logic        reset;
  logic [31:0] pat    [3];
  logic [15:0] j1     [3];
  logic [15:0] j2     [3];
  logic        stb    [3];
  logic        pres   [3];
  logic        jclk   [3];
  logic        jload  [3];
  int          seen20 [3];
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nb_of(input int g);
    return (g == 2) ? 16 : 12;
  endfunction

  // Wire image of a button set: active-low, player 1 in bits 0.., player 2 above.
  function automatic logic [31:0] make_wire(input int nb, input logic [15:0] p1, input logic [15:0] p2);
    logic [31:0] v;
    v = '1;
    for (int i = 0; i < nb; i++) begin
      v[i]      = ~p1[i];
      v[nb + i] = ~p2[i];
    end
    return v;
  endfunction

  task automatic set_all(input logic [15:0] p1, input logic [15:0] p2);
    for (int g = 0; g < 3; g++) pat[g] = make_wire(nb_of(g), p1, p2);
  endtask

  task automatic set_stuck();
    for (int g = 0; g < 3; g++) pat[g] = '0;
  endtask

  task automatic wait_stb(input int g);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!stb[g] && n < 5000);
    check("stb_timeout", 32'(stb[g]), 1);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int NB  = (g == 2) ? 16 : 12;
    localparam int CD  = (g == 2) ? 6 : 4;
    localparam int DEB = (g == 1) ? 1 : 2;
    localparam int P   = 64 + 2 * CD + 4 * NB * CD + 1;

    db15_serial_reader_if bus ();

    db15_serial_reader #(
      .CLK_DIV    (CD),
      .NBITS      (NB),
      .GAP        (64),
      .DEB_FRAMES (DEB)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .joy       (bus),
      .joystick1 (j1[g]),
      .joystick2 (j2[g]),
      .frame_stb (stb[g]),
      .present   (pres[g])
    );

    assign jclk[g]  = bus.joy_clk;
    assign jload[g] = bus.joy_load;

    // Adapter: latches the wire image on load, advances on each rising clock.
    logic [31:0] sh = '1;
    logic [31:0] cap [$];
    always @(negedge bus.joy_load or posedge bus.joy_clk) begin
      if (!bus.joy_load) begin
        sh = pat[g];
        cap.push_back(pat[g]);
      end else begin
        sh = sh >> 1;
      end
    end
    assign bus.joy_data = sh[0];

    int          cyc;
    int          last;
    int          ld_run;
    int          ck_run;
    int          pulses;
    bit          seen_first;
    logic [15:0] e1, e2;
    logic        ep;
    logic [31:0] hist [$];

    always @(posedge clk) cyc = reset ? 0 : cyc + 1;

    always @(negedge clk) begin
      if (reset) begin
        cap.delete();
        hist.delete();
        hist.push_back(32'h0);
        e1 = '0; e2 = '0; ep = 1'b0;
        seen_first = 1'b0;
        ld_run = 0; ck_run = 0; pulses = 0;
      end else begin
        if (!jload[g]) ld_run++;
        else if (ld_run != 0) begin
          check($sformatf("load_low_len%0d", g), ld_run, 2 * CD);
          ld_run = 0;
        end
        if (!jclk[g]) ck_run++;
        else if (ck_run != 0) begin
          check($sformatf("clk_low_len%0d", g), ck_run, CD);
          pulses++;
          ck_run = 0;
        end
        if (stb[g]) begin
          logic [31:0] raw, mask;
          bit stable;
          check($sformatf("clk_pulses%0d", g), pulses, 2 * NB);
          pulses = 0;
          if (!seen_first) check($sformatf("first_stb_latency%0d", g), cyc, P);
          else             check($sformatf("frame_period%0d", g), cyc - last, P);
          last = cyc;
          seen_first = 1'b1;
          check($sformatf("frame_queued%0d", g), 32'(cap.size() != 0), 1);
          mask = 32'((64'd1 << (2 * NB)) - 64'd1);
          raw  = (cap.size() != 0) ? (cap.pop_front() & mask) : 32'h0;
          hist.push_back(raw);
          if (hist.size() > 4) void'(hist.pop_front());
          if (raw == 32'h0) begin
            e1 = '0; e2 = '0; ep = 1'b0;
          end else begin
            ep = 1'b1;
            stable = 1'b1;
            for (int k = 1; k <= DEB; k++)
              if (hist.size() < k || hist[hist.size() - k] != raw) stable = 1'b0;
            if (stable) begin
              e1 = '0; e2 = '0;
              for (int i = 0; i < NB; i++) begin
                e1[i] = ~raw[i];
                e2[i] = ~raw[NB + i];
              end
            end
          end
          if (j1[g] == 16'h0020) seen20[g]++;
        end
        if (stb[g] || (cyc % 8) == 0) begin
          check($sformatf("joystick1_%0d", g), j1[g], e1);
          check($sformatf("joystick2_%0d", g), j2[g], e2);
          check($sformatf("present%0d", g), 32'(pres[g]), 32'(ep));
        end
      end
    end
  end

  initial begin
    int n, falls, d, k, r;
    logic prev;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int g = 0; g < 3; g++) seen20[g] = 0;
    set_all(16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check("rst_joy_clk", 32'(jclk[g]), 1);
      check("rst_joy_load", 32'(jload[g]), 1);
      check("rst_joystick1", j1[g], 0);
      check("rst_joystick2", j2[g], 0);
      check("rst_frame_stb", 32'(stb[g]), 0);
      check("rst_present", 32'(pres[g]), 0);
    end
    #1 reset = 1'b0;

    // Nothing pressed.
    wait_stb(0);
    check("idle_joystick1", j1[0], 16'h0);
    check("idle_present", 32'(pres[0]), 1);
    wait_stb(0);

    // Held buttons need two matching frames with the default debounce.
    set_all(16'h0001, 16'h0008);
    wait_stb(0);
    check("held_after1_j1", j1[0], 16'h0);
    check("held_after1_j2", j2[0], 16'h0);
    check("held_deb1_j1", j1[1], 16'h0001);
    wait_stb(0);
    check("held_after2_j1", j1[0], 16'h0001);
    check("held_after2_j2", j2[0], 16'h0008);

    // Single-frame glitch on player 1 bit 5.
    set_all(16'h0, 16'h0);
    wait_stb(0);
    wait_stb(0);
    seen20[0] = 0;
    seen20[1] = 0;
    set_all(16'h0020, 16'h0);
    wait_stb(0);
    set_all(16'h0, 16'h0);
    wait_stb(0);
    wait_stb(0);
    check("glitch_deb2_seen", seen20[0], 0);
    check("glitch_deb1_seen", seen20[1], 1);

    // Data stuck low, then released.
    set_stuck();
    wait_stb(0);
    wait_stb(0);
    check("stuck_present", 32'(pres[0]), 0);
    check("stuck_joystick1", j1[0], 16'h0);
    set_all(16'h0, 16'h0);
    wait_stb(0);
    check("release_present", 32'(pres[0]), 1);

    // Reset in the middle of bit 10.
    set_all(16'h0ABC, 16'h0123);
    wait_stb(0);
    wait_stb(0);
    check("pre_reset_j1", j1[0], 16'h0ABC);
    n = 0;
    while (jload[0] && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("load_seen", 32'(jload[0]), 0);
    falls = 0;
    n = 0;
    prev = jclk[0];
    while (falls < 11 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (prev && !jclk[0]) falls++;
      prev = jclk[0];
    end
    check("bit10_reached", falls, 11);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_joy_clk", 32'(jclk[0]), 1);
    check("midrst_joy_load", 32'(jload[0]), 1);
    check("midrst_joystick1", j1[0], 16'h0);
    check("midrst_joystick2", j2[0], 16'h0);
    #1 reset = 1'b0;
    n = 0;
    while (jload[0] && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("load_after_reset", n, 64);

    // Randomized frames, stuck periods and occasional resets.
    for (int it = 0; it < 40; it++) begin
      wait_stb(0);
      r = $urandom_range(0, 9);
      if (r >= 4 && r < 8) begin
        set_all(16'($urandom), 16'($urandom));
      end else if (r == 8) begin
        set_stuck();
      end else if (r == 9) begin
        d = $urandom_range(1, 250);
        k = $urandom_range(1, 3);
        repeat (d) @(posedge clk);
        #2 reset = 1'b1;
        repeat (k) @(posedge clk);
        #2 reset = 1'b0;
      end
    end

    // Wide frame on the NBITS=16, CLK_DIV=6 instance.
    set_all(16'hAAAA, 16'h5555);
    wait_stb(2);
    wait_stb(2);
    wait_stb(2);
    check("wide_joystick1", j1[2], 16'hAAAA);
    check("wide_joystick2", j2[2], 16'h5555);

    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
